// File: rtl/c16_audio_mix_if.sv
// Channel inputs and mixed-sample outputs of the C16 audio mixer.
// The master side drives the channels; the slave side is the mixer.
interface c16_audio_mix_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned IN_W     = 17,
  parameter int unsigned OUT_W    = 16
);
  logic [CHANNELS*IN_W-1:0] ch_in;
  logic [CHANNELS*4-1:0]    ch_gain;
  logic [CHANNELS-1:0]      ch_mute;
  logic [OUT_W-1:0]         sound;
  logic                     sample_valid;
  logic                     clip;
  logic                     period_ce;

  modport master (
    output ch_in, ch_gain, ch_mute,
    input  sound, sample_valid, clip, period_ce
  );

  modport slave (
    input  ch_in, ch_gain, ch_mute,
    output sound, sample_valid, clip, period_ce
  );
endinterface

// File: rtl/c16_audio_mix.sv
// Time-multiplexed N-channel audio mixer: snapshot once per period, one MAC
// per clock, saturate to OUT_W and present a registered sample with strobe.
module c16_audio_mix #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned IN_W     = 17,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned DIV      = 29
) (
  input  logic             CLK28,
  input  logic             RESET,
  c16_audio_mix_if.slave   bus
);
  localparam int unsigned PROD_W = IN_W + 5;
  localparam int unsigned ACC_W  = PROD_W + $clog2(CHANNELS);
  localparam int unsigned CNT_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned DIV_W  = $clog2(DIV);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (OUT_W - 1)));

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SAT} state_t;

  state_t                   state_q, state_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [CNT_W-1:0]         k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CHANNELS*IN_W-1:0] x_q, x_d;
  logic [CHANNELS*4-1:0]    g_q, g_d;
  logic [CHANNELS-1:0]      m_q, m_d;
  logic [OUT_W-1:0]         sound_q, sound_d;
  logic                     clip_q, clip_d;
  logic                     sample_valid_q, sample_valid_d;
  logic                     period_ce_q, period_ce_d;

  logic signed [IN_W-1:0]   x_sel;
  logic signed [4:0]        g_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  term;

  always_ff @(posedge CLK28) begin
    if (RESET) begin
      state_q        <= S_IDLE;
      div_q          <= '0;
      k_q            <= '0;
      acc_q          <= '0;
      x_q            <= '0;
      g_q            <= '0;
      m_q            <= '0;
      sound_q        <= '0;
      clip_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      period_ce_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      k_q            <= k_d;
      acc_q          <= acc_d;
      x_q            <= x_d;
      g_q            <= g_d;
      m_q            <= m_d;
      sound_q        <= sound_d;
      clip_q         <= clip_d;
      sample_valid_q <= sample_valid_d;
      period_ce_q    <= period_ce_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    acc_d          = acc_q;
    x_d            = x_q;
    g_d            = g_q;
    m_d            = m_q;
    sound_d        = sound_q;
    clip_d         = clip_q;
    sample_valid_d = 1'b0;
    div_d          = (div_q == DIV_W'(DIV - 1)) ? '0 : div_q + DIV_W'(1);
    period_ce_d    = (div_d == '0);

    // Gain is unsigned; a zero sign bit keeps the product signed-correct.
    x_sel = x_q[k_q*IN_W +: IN_W];
    g_sel = {1'b0, g_q[k_q*4 +: 4]};
    prod  = PROD_W'(x_sel) * PROD_W'(g_sel);
    term  = m_q[k_q] ? '0 : ACC_W'(prod >>> 3);

    case (state_q)
      S_IDLE: begin
        if (div_q == '0) begin
          x_d     = bus.ch_in;
          g_d     = bus.ch_gain;
          m_d     = bus.ch_mute;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_d = acc_q + term;
        k_d   = k_q + CNT_W'(1);
        if (k_q == CNT_W'(CHANNELS - 1)) state_d = S_SAT;
      end
      S_SAT: begin
        if (acc_q > SAT_MAX) begin
          sound_d = OUT_W'(SAT_MAX);
          clip_d  = 1'b1;
        end else if (acc_q < SAT_MIN) begin
          sound_d = OUT_W'(SAT_MIN);
          clip_d  = 1'b1;
        end else begin
          sound_d = acc_q[OUT_W-1:0];
          clip_d  = 1'b0;
        end
        sample_valid_d = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.sound        = sound_q;
  assign bus.clip         = clip_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.period_ce    = period_ce_q;
endmodule

// File: tb/tb_c16_audio_mix.sv
// Self-checking bench for c16_audio_mix: directed vector table, hand-written
// timing sequences and randomized periods against an arithmetic reference.
module tb_c16_audio_mix;
  localparam int unsigned CH = 4;
  localparam int unsigned IW = 17;
  localparam int unsigned OW = 16;
  localparam int unsigned DV = 29;

  logic CLK28 = 1'b0;
  logic RESET;
  always #5 CLK28 = ~CLK28;

  c16_audio_mix_if #(.CHANNELS(CH), .IN_W(IW), .OUT_W(OW)) bus_if ();
  c16_audio_mix #(.CHANNELS(CH), .IN_W(IW), .OUT_W(OW), .DIV(DV)) dut (
    .CLK28(CLK28),
    .RESET(RESET),
    .bus  (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int       x[4];
    int       g[4];
    bit [3:0] m;
    int       exp_s;
    bit       exp_c;
    string    name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int x0, input int x1, input int x2, input int x3,
                              input int g0, input int g1, input int g2, input int g3,
                              input bit [3:0] m, input int es, input bit ec, input string nm);
    vec_t v;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
    v.g[0] = g0; v.g[1] = g1; v.g[2] = g2; v.g[3] = g3;
    v.m = m; v.exp_s = es; v.exp_c = ec; v.name = nm;
    return v;
  endfunction

  task automatic apply(input int x[4], input int g[4], input bit [3:0] m);
    for (int k = 0; k < 4; k++) begin
      bus_if.ch_in[k*IW +: IW] = IW'(x[k]);
      bus_if.ch_gain[k*4 +: 4] = 4'(g[k]);
    end
    bus_if.ch_mute = m;
  endtask

  // Reference: floor(x*g/8) per unmuted channel, summed exactly, then clamped.
  task automatic model(input int x[4], input int g[4], input bit [3:0] m,
                       output int s, output bit c);
    longint sum = 0;
    for (int k = 0; k < 4; k++) begin
      if (!m[k]) begin
        longint p = longint'(x[k]) * longint'(g[k]);
        longint q = p / 8;
        if (p < 0 && (p % 8) != 0) q = q - 1;
        sum += q;
      end
    end
    c = 1'b1;
    if (sum > 32767) s = 32767;
    else if (sum < -32768) s = -32768;
    else begin
      s = int'(sum);
      c = 1'b0;
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK28);
      if (bus_if.sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL sample_valid_timeout: got no strobe, expected one within 64 cycles");
    end
  endtask

  task automatic wait_period(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK28);
      if (bus_if.period_ce) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL period_ce_timeout: got no strobe, expected one within 64 cycles");
    end
  endtask

  task automatic expect_sample(input string name, input int es, input bit ec);
    bit ok;
    wait_valid(ok);
    if (ok) begin
      check({name, "_sound"}, int'($signed(bus_if.sound)), es);
      check({name, "_clip"}, int'(bus_if.clip), int'(ec));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int       first_i;
    int       sv_err;
    int       pce_err;
    bit       ok;
    int       rx[4];
    int       rg[4];
    bit [3:0] rm;
    int       rs;
    bit       rc;

    vecs[0] = mk(1000, -300, 0, 0,  4, 8, 0, 0, 4'b1100, 200, 1'b0, "unity_scale");
    vecs[1] = mk(-3, 0, 0, 0,       1, 0, 0, 0, 4'b1110, -1, 1'b0, "floor_neg");
    vecs[2] = mk(3, 0, 0, 0,        1, 0, 0, 0, 4'b1110, 0, 1'b0, "floor_pos");
    vecs[3] = mk(20000, 20000, 20000, 20000, 8, 8, 8, 8, 4'b0000, 32767, 1'b1, "sat_pos");
    vecs[4] = mk(-20000, -20000, -20000, -20000, 8, 8, 8, 8, 4'b0000, -32768, 1'b1, "sat_neg");
    vecs[5] = mk(0, 0, 0, 0,        8, 8, 8, 8, 4'b0000, 0, 1'b0, "zero_unclip");
    vecs[6] = mk(800, 1234, 0, 0,   15, 0, 0, 0, 4'b1100, 1500, 1'b0, "gain_15_and_0");
    vecs[7] = mk(100, -1, 500, 0,   8, 1, 8, 0, 4'b0101, -1, 1'b0, "mute_nonzero");

    // Reset behaviour and first-sample latency.
    RESET = 1'b1;
    apply(vecs[0].x, vecs[0].g, vecs[0].m);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK28);
      check("reset_sound", int'(bus_if.sound), 0);
      check("reset_sample_valid", int'(bus_if.sample_valid), 0);
    end
    RESET = 1'b0;

    first_i = -1;
    sv_err  = 0;
    pce_err = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge CLK28);
      if (bus_if.sample_valid && first_i < 0) first_i = i;
      if (bus_if.sample_valid !== ((i % 29) == 6)) sv_err++;
      if (bus_if.period_ce !== ((i % 29) == 0)) pce_err++;
      if (i == 6) check("first_sample_sound", int'($signed(bus_if.sound)), 200);
    end
    check("first_valid_cycle", first_i + 1, 7);
    check("sample_valid_pattern_errors", sv_err, 0);
    check("period_ce_pattern_errors", pce_err, 0);

    // Directed vector table; each applied while the engine is idle.
    for (int v = 0; v < 8; v++) begin
      apply(vecs[v].x, vecs[v].g, vecs[v].m);
      expect_sample(vecs[v].name, vecs[v].exp_s, vecs[v].exp_c);
    end

    // Randomized periods against the reference model.
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 4; k++) begin
        rx[k] = int'($urandom_range(131071, 0)) - 65536;
        rg[k] = int'($urandom_range(15, 0));
      end
      rm = 4'($urandom);
      model(rx, rg, rm, rs, rc);
      apply(rx, rg, rm);
      expect_sample("random", rs, rc);
    end

    // Snapshot isolation: a change at div==1 lands in the next period.
    rx = '{100, 0, 0, 0};
    rg = '{8, 8, 8, 8};
    apply(rx, rg, 4'b1110);
    wait_period(ok);
    @(negedge CLK28);
    rx[0] = 5000;
    apply(rx, rg, 4'b1110);
    expect_sample("isolation_this", 100, 1'b0);
    expect_sample("isolation_next", 5000, 1'b0);

    // One-cycle reset at t+2 aborts the period.
    rx[0] = 700;
    apply(rx, rg, 4'b1110);
    wait_period(ok);
    @(negedge CLK28);
    @(negedge CLK28);
    RESET = 1'b1;
    @(negedge CLK28);
    RESET = 1'b0;
    check("midreset_sound", int'($signed(bus_if.sound)), 0);
    check("midreset_sample_valid", int'(bus_if.sample_valid), 0);
    sv_err = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK28);
      if (i < 6 && bus_if.sample_valid) sv_err++;
      if (i < 6 && bus_if.sound !== '0) sv_err++;
      if (i == 6) begin
        check("post_reset_valid", int'(bus_if.sample_valid), 1);
        check("post_reset_sound", int'($signed(bus_if.sound)), 700);
      end
    end
    check("aborted_period_quiet", sv_err, 0);
    @(negedge CLK28);
    check("strobe_one_cycle", int'(bus_if.sample_valid), 0);
    check("sound_held", int'($signed(bus_if.sound)), 700);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
